// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered one-hot channel decoder/scanner.
`timescale 1ns/1ps
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic state_t mode_to_state(input logic mode);
    return (mode == MODE_SCAN) ? SCAN : DIRECT;
  endfunction

endpackage

// File: rtl/decoder_scan_onehot.sv
// Combinational one-hot decoder: drives bit x of y when en is high, else all zero.
`timescale 1ns/1ps
module decoder_scan_onehot #(
  parameter int M = 3,
  parameter int N = 1 << M
) (
  input  logic         en,
  input  logic [M-1:0] x,
  output logic [N-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[x] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with a DIRECT hold mode and a SCAN mode that rotates
// the selected channel every (dwell + 1) cycles behind a val/rdy request port.
`timescale 1ns/1ps
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int M       = 3,
  parameter int N       = 1 << M,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [M-1:0]       recv_msg,
  input  logic               recv_val,
  output logic               recv_rdy,
  output logic [N-1:0]       y,
  output logic               y_val,
  output logic [M-1:0]       sel_idx,
  output logic               wrap
);

  state_t             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [M-1:0]       idx_n;
  logic               val_n;
  logic               wrap_n;
  logic [N-1:0]       y_n;
  logic               hs;

  assign recv_rdy = enable;
  assign hs       = recv_val && recv_rdy;

  // A handshake always restarts from the sampled request; otherwise only SCAN moves.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dwell_n = dwell_q;
    idx_n   = sel_idx;
    val_n   = y_val;
    wrap_n  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      val_n   = 1'b0;
    end else if (hs) begin
      state_n = mode_to_state(mode);
      cnt_n   = '0;
      dwell_n = dwell;
      idx_n   = recv_msg;
      val_n   = 1'b1;
    end else if (state == SCAN) begin
      if (cnt == dwell_q) begin
        cnt_n  = '0;
        idx_n  = sel_idx + M'(1);
        wrap_n = (sel_idx == M'(N - 1));
      end else begin
        cnt_n = cnt + DWELL_W'(1);
      end
    end
  end

  decoder_scan_onehot #(.M(M), .N(N)) u_onehot (
    .en (val_n),
    .x  (idx_n),
    .y  (y_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dwell_q <= '0;
      sel_idx <= '0;
      y       <= '0;
      y_val   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      dwell_q <= dwell_n;
      sel_idx <= idx_n;
      y       <= y_n;
      y_val   <= val_n;
      wrap    <= wrap_n;
    end
  end

  // Output invariants: y is zero or exactly the bit named by sel_idx.
  a_onehot: assert property (@(posedge clk) disable iff (!reset)
    y_val |-> (y == (N'(1) << sel_idx)));
  a_idle_zero: assert property (@(posedge clk) disable iff (!reset)
    !y_val |-> (y == '0));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset)
    cnt <= dwell_q);
  a_wrap_scan: assert property (@(posedge clk) disable iff (!reset)
    wrap |-> (y_val && sel_idx == '0));

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: directed scenarios plus random traffic
// compared against a time-based model of channel position.
`timescale 1ns/1ps
module tb_decoder_scan;

  localparam int M  = 3;
  localparam int N  = 1 << M;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          mode;
  logic [DW-1:0] dwell;
  logic [M-1:0]  recv_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [N-1:0]  y;
  logic          y_val;
  logic [M-1:0]  sel_idx;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: active flag, mode, start channel, cycles since start, dwell.
  bit m_act  = 0;
  bit m_scan = 0;
  int m_start = 0;
  int m_t     = 0;
  int m_d     = 0;

  decoder_scan #(.M(M), .N(N), .DWELL_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .dwell    (dwell),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .y        (y),
    .y_val    (y_val),
    .sel_idx  (sel_idx),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic int m_idx();
    if (m_scan) return (m_start + m_t / (m_d + 1)) % N;
    return m_start;
  endfunction

  function automatic bit m_wrap();
    return m_act && m_scan && (m_t > 0) && (m_t % (m_d + 1) == 0) && (m_idx() == 0);
  endfunction

  function automatic logic [12:0] m_vec();
    logic [N-1:0] ey;
    logic [M-1:0] ei;
    ey = m_act ? N'(1 << m_idx()) : '0;
    ei = m_act ? M'(m_idx()) : '0;
    return {ey, m_act, m_wrap(), ei};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {y, y_val, wrap, (m_act ? sel_idx : M'(0))};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset || !enable) m_act = 0;
    else if (recv_val) begin
      m_act = 1; m_scan = mode; m_start = int'(recv_msg); m_t = 0; m_d = int'(dwell);
    end else if (m_act && m_scan) m_t++;
    #1;
  endtask

  task automatic send(input logic md, input int msg, input int dw);
    mode = md; recv_msg = M'(msg); dwell = DW'(dw); recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; mode = 1'b0; dwell = '0; recv_msg = '0; recv_val = 1'b0;
    #12;
    checks++;
    if ({y, y_val, wrap, sel_idx} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h want=0", {y, y_val, wrap, sel_idx});
    end
    reset = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    checks++;
    if (recv_rdy !== 1'b1 || y !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idle rdy=%b y=%h want rdy=1 y=0", recv_rdy, y);
    end
  endtask

  task automatic test_direct();
    send(1'b0, 5, 0);
    checks++;
    if (y !== 8'b0010_0000 || sel_idx !== 3'd5 || y_val !== 1'b1) begin
      errors++;
      $display("[TB] FAIL direct_decode y=%b sel=%0d val=%b want y=00100000 sel=5 val=1", y, sel_idx, y_val);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs_vec() !== m_vec()) begin
        errors++;
        $display("[TB] FAIL direct_hold cyc=%0d got=%h want=%h", i, obs_vec(), m_vec());
      end
    end
  endtask

  task automatic test_scan_dwell2();
    int wraps = 0;
    send(1'b1, 6, 2);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs_vec() !== m_vec()) begin
        errors++;
        $display("[TB] FAIL scan_dwell2 cyc=%0d got=%h want=%h", i, obs_vec(), m_vec());
      end
      if (wrap) wraps++;
      if (i == 6 && (y !== 8'b0000_0001 || wrap !== 1'b1)) begin
        errors++;
        $display("[TB] FAIL scan_dwell2_wrap y=%b wrap=%b want y=00000001 wrap=1", y, wrap);
      end
      tick();
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("[TB] FAIL scan_dwell2_wrapcount got=%0d want=1", wraps);
    end
  endtask

  task automatic test_scan_dwell0();
    int wraps = 0;
    send(1'b1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs_vec() !== m_vec() || sel_idx !== M'(i % N)) begin
        errors++;
        $display("[TB] FAIL scan_dwell0 cyc=%0d got=%h want=%h", i, obs_vec(), m_vec());
      end
      if (wrap) wraps++;
      tick();
    end
    checks++;
    if (wraps != 2) begin
      errors++;
      $display("[TB] FAIL scan_dwell0_wrapcount got=%0d want=2", wraps);
    end
  endtask

  task automatic test_restart();
    int guard = 0;
    send(1'b1, 2, 1);
    while (m_idx() != 3 && guard < 50) begin
      tick();
      guard++;
    end
    send(1'b0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (y !== 8'b0000_0010 || wrap !== 1'b0 || obs_vec() !== m_vec()) begin
        errors++;
        $display("[TB] FAIL restart_direct cyc=%0d y=%b wrap=%b want y=00000010 wrap=0", i, y, wrap);
      end
      mode = 1'b1;
      tick();
    end
    mode = 1'b0;
  endtask

  task automatic test_enable_drop();
    send(1'b1, 4, 1);
    tick();
    enable = 1'b0; recv_val = 1'b1; mode = 1'b0; recv_msg = 3'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (y !== '0 || y_val !== 1'b0 || recv_rdy !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("[TB] FAIL enable_drop cyc=%0d y=%b val=%b rdy=%b want 0 0 0", i, y, y_val, recv_rdy);
      end
    end
    recv_val = 1'b0; enable = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== m_vec()) begin
      errors++;
      $display("[TB] FAIL enable_return got=%h want=%h", obs_vec(), m_vec());
    end
  endtask

  task automatic test_async_reset();
    send(1'b1, 0, 0);
    tick(); tick();
    #3;
    reset = 1'b0;
    m_act = 0;
    #1;
    checks++;
    if (y !== '0 || y_val !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset y=%b val=%b wrap=%b want 0 0 0", y, y_val, wrap);
    end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (y !== '0 || y_val !== 1'b0 || obs_vec() !== m_vec()) begin
        errors++;
        $display("[TB] FAIL after_reset cyc=%0d y=%b val=%b want 0 0", i, y, y_val);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 19) != 0);
      recv_val = ($urandom_range(0, 9) == 0);
      mode     = 1'($urandom_range(0, 1));
      recv_msg = M'($urandom_range(0, N - 1));
      dwell    = DW'($urandom_range(0, 3));
      tick();
      checks++;
      if (obs_vec() !== m_vec() || recv_rdy !== enable) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d got=%h want=%h rdy=%b", i, obs_vec(), m_vec(), recv_rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_dwell2();
    test_scan_dwell0();
    test_restart();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
